// File: rtl/drbg_out_buffer.sv
// Sequencer and output buffer for an AES-128 CTR_DRBG core.
// Latency: a block pushed into an empty FIFO is visible on out_valid_o the next cycle;
// command pulses are registered and appear one cycle after the FSM decides to issue.
// Backpressure: out_ready_i low holds out_data_o; a generate is issued only when BATCH slots are free.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   enable_i                         gates new instantiate/generate/reseed commands
//   drbg_*_o                         command pulses and fixed batch size toward the DRBG
//   drbg_done_i, drbg_random_*_i     completion pulse and random block stream from the DRBG
//   out_valid_o/out_ready_i/out_data_o  serialized word stream, most significant word first
//   level_o, seeded_o, overflow_o, short_err_o  status (overflow and short_err are sticky)
module drbg_out_buffer #(
    parameter int DEPTH           = 4,
    parameter int BATCH           = 2,
    parameter int OUT_BITS        = 32,
    parameter int RESEED_INTERVAL = 510
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable_i,
    output logic                       drbg_instantiate_o,
    output logic                       drbg_reseed_o,
    output logic                       drbg_generate_o,
    output logic [15:0]                drbg_num_blocks_o,
    input  logic                       drbg_done_i,
    input  logic                       drbg_random_valid_i,
    input  logic [127:0]               drbg_random_block_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [OUT_BITS-1:0]        out_data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       seeded_o,
    output logic                       overflow_o,
    output logic                       short_err_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int WPB = 128 / OUT_BITS;
    localparam int WIW = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int GCW = $clog2(RESEED_INTERVAL + 1);
    // rcvd saturates at BATCH+1 so an over-delivering DRBG still reads as "not BATCH"
    localparam int RCW = $clog2(BATCH + 2);

    typedef enum logic [2:0] {
        S_INIT,
        S_INIT_WAIT,
        S_IDLE,
        S_GEN_WAIT,
        S_RESEED_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Block FIFO
    // ------------------------------------------------------------------
    logic [127:0]         mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        count;
    logic [WIW-1:0]       word_idx;

    logic                 xfer;
    logic                 last_word;
    logic                 pop;
    logic                 push;
    logic                 push_drop;
    logic [LW-1:0]        free_slots;
    logic [127:0]         head;
    logic [OUT_BITS-1:0]  words [WPB];

    assign out_valid_o = (count != '0);
    assign xfer        = out_valid_o && out_ready_i;
    assign last_word   = (word_idx == WIW'(WPB - 1));
    assign pop         = xfer && last_word;
    // A pop in the same cycle frees the slot the incoming block needs.
    assign push        = drbg_random_valid_i && ((count != LW'(DEPTH)) || pop);
    assign push_drop   = drbg_random_valid_i && !push;
    assign free_slots  = LW'(DEPTH) - count;
    assign level_o     = count;

    assign head = mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < WPB; i++) begin
            words[i] = head[(WPB - 1 - i) * OUT_BITS +: OUT_BITS];
        end
    end

    // Output is masked to zero when empty so stale storage never shows.
    assign out_data_o = out_valid_o ? words[word_idx] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= drbg_random_block_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            word_idx   <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                word_idx <= '0;
            end else if (xfer) begin
                word_idx <= word_idx + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command sequencer
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_n;
    logic [GCW-1:0]    gen_count;
    logic [GCW-1:0]    gen_count_n;
    logic [RCW-1:0]    rcvd;
    logic [RCW-1:0]    rcvd_n;
    logic [RCW-1:0]    rcvd_eff;
    logic              seeded_n;
    logic              short_n;
    logic              inst_n;
    logic              reseed_n;
    logic              gen_n;

    assign drbg_num_blocks_o = 16'(BATCH);

    // Includes a block arriving in the same cycle as done.
    assign rcvd_eff = (drbg_random_valid_i && (rcvd != RCW'(BATCH + 1))) ? rcvd + 1'b1 : rcvd;

    always_comb begin
        state_n     = state;
        gen_count_n = gen_count;
        rcvd_n      = rcvd;
        seeded_n    = seeded_o;
        short_n     = short_err_o;
        inst_n      = 1'b0;
        reseed_n    = 1'b0;
        gen_n       = 1'b0;
        case (state)
            S_INIT: begin
                if (enable_i) begin
                    inst_n  = 1'b1;
                    state_n = S_INIT_WAIT;
                end
            end
            S_INIT_WAIT: begin
                if (drbg_done_i) begin
                    seeded_n    = 1'b1;
                    gen_count_n = '0;
                    state_n     = S_IDLE;
                end
            end
            S_IDLE: begin
                if (enable_i) begin
                    if (gen_count == GCW'(RESEED_INTERVAL)) begin
                        reseed_n = 1'b1;
                        state_n  = S_RESEED_WAIT;
                    end else if (free_slots >= LW'(BATCH)) begin
                        gen_n   = 1'b1;
                        rcvd_n  = '0;
                        state_n = S_GEN_WAIT;
                    end
                end
            end
            S_GEN_WAIT: begin
                rcvd_n = rcvd_eff;
                if (drbg_done_i) begin
                    state_n = S_IDLE;
                    if (rcvd_eff != RCW'(BATCH)) begin
                        // A short or rejected generate forces a reseed next.
                        short_n     = 1'b1;
                        gen_count_n = GCW'(RESEED_INTERVAL);
                    end else begin
                        gen_count_n = gen_count + 1'b1;
                    end
                end
            end
            S_RESEED_WAIT: begin
                if (drbg_done_i) begin
                    gen_count_n = '0;
                    state_n     = S_IDLE;
                end
            end
            default: begin
                state_n = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_INIT;
            gen_count          <= '0;
            rcvd               <= '0;
            seeded_o           <= 1'b0;
            short_err_o        <= 1'b0;
            drbg_instantiate_o <= 1'b0;
            drbg_reseed_o      <= 1'b0;
            drbg_generate_o    <= 1'b0;
        end else begin
            state              <= state_n;
            gen_count          <= gen_count_n;
            rcvd               <= rcvd_n;
            seeded_o           <= seeded_n;
            short_err_o        <= short_n;
            drbg_instantiate_o <= inst_n;
            drbg_reseed_o      <= reseed_n;
            drbg_generate_o    <= gen_n;
        end
    end

endmodule

// File: tb/tb_drbg_out_buffer.sv
module tb_drbg_out_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable_i;
    logic         drbg_instantiate_o;
    logic         drbg_reseed_o;
    logic         drbg_generate_o;
    logic [15:0]  drbg_num_blocks_o;
    logic         drbg_done_i;
    logic         drbg_random_valid_i;
    logic [127:0] drbg_random_block_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [31:0]  out_data_o;
    logic [2:0]   level_o;
    logic         seeded_o;
    logic         overflow_o;
    logic         short_err_o;

    int errors = 0;
    int checks = 0;
    logic [127:0] cb [6];

    always #5 clk = ~clk;

    drbg_out_buffer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable_i            (enable_i),
        .drbg_instantiate_o  (drbg_instantiate_o),
        .drbg_reseed_o       (drbg_reseed_o),
        .drbg_generate_o     (drbg_generate_o),
        .drbg_num_blocks_o   (drbg_num_blocks_o),
        .drbg_done_i         (drbg_done_i),
        .drbg_random_valid_i (drbg_random_valid_i),
        .drbg_random_block_i (drbg_random_block_i),
        .out_valid_o         (out_valid_o),
        .out_ready_i         (out_ready_i),
        .out_data_o          (out_data_o),
        .level_o             (level_o),
        .seeded_o            (seeded_o),
        .overflow_o          (overflow_o),
        .short_err_o         (short_err_o)
    );

    // Drive and sample 1ns after the falling edge, far from the rising edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // kind: 0 none within limit, 1 instantiate, 2 reseed, 3 generate.
    task automatic wait_cmd(input int limit, output int kind, output int cycles);
        kind   = 0;
        cycles = 0;
        for (int c = 0; c < limit; c++) begin
            #1;
            if (drbg_instantiate_o) begin kind = 1; cycles = c; return; end
            if (drbg_reseed_o)      begin kind = 2; cycles = c; return; end
            if (drbg_generate_o)    begin kind = 3; cycles = c; return; end
            step();
        end
        cycles = limit;
    endtask

    // DRBG model answering a generate with two blocks then done.
    task automatic answer(input logic [127:0] b0, input logic [127:0] b1);
        drbg_random_valid_i = 1'b1;
        drbg_random_block_i = b0;
        step();
        drbg_random_block_i = b1;
        step();
        drbg_random_valid_i = 1'b0;
        drbg_done_i         = 1'b1;
        step();
        drbg_done_i         = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable_i = 1'b0; out_ready_i = 1'b0;
        drbg_done_i = 1'b0; drbg_random_valid_i = 1'b0; drbg_random_block_i = '0;
        repeat (3) step();
        checks++;
        if ({drbg_instantiate_o, drbg_reseed_o, drbg_generate_o} !== 3'b000) begin
            errors++; $display("FAIL reset_cmds: got %b want 000", {drbg_instantiate_o, drbg_reseed_o, drbg_generate_o});
        end
        checks++;
        if ({out_valid_o, seeded_o, overflow_o, short_err_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {out_valid_o, seeded_o, overflow_o, short_err_o});
        end
        checks++;
        if (level_o !== 3'd0 || out_data_o !== 32'h0) begin
            errors++; $display("FAIL reset_level_data: got %0d/%h want 0/00000000", level_o, out_data_o);
        end
        checks++;
        if (drbg_num_blocks_o !== 16'd2) begin
            errors++; $display("FAIL num_blocks: got %0d want 2", drbg_num_blocks_o);
        end
    endtask

    task automatic test_init();
        int kind, cyc;
        rst_n = 1'b1; enable_i = 1'b1;
        wait_cmd(5, kind, cyc);
        checks++;
        if (kind != 1 || cyc != 1) begin
            errors++; $display("FAIL init_cmd: got kind %0d at cycle %0d want kind 1 at cycle 1", kind, cyc);
        end
        checks++;
        if (seeded_o !== 1'b0) begin
            errors++; $display("FAIL seeded_early: got %b want 0", seeded_o);
        end
        step();
        drbg_done_i = 1'b1;
        step();
        drbg_done_i = 1'b0;
        checks++;
        if (seeded_o !== 1'b1) begin
            errors++; $display("FAIL seeded: got %b want 1", seeded_o);
        end
        wait_cmd(5, kind, cyc);
        checks++;
        if (kind != 3) begin
            errors++; $display("FAIL first_gen: got kind %0d want 3", kind);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_w [8];
        exp_w = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
                  32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        step();
        enable_i = 1'b0;
        drbg_random_valid_i = 1'b1;
        drbg_random_block_i = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        step();
        checks++;
        if (level_o !== 3'd1 || out_valid_o !== 1'b1 || out_data_o !== 32'h00112233) begin
            errors++; $display("FAIL first_push: got lvl %0d vld %b data %h want 1 1 00112233", level_o, out_valid_o, out_data_o);
        end
        drbg_random_block_i = 128'h01020304_05060708_090A0B0C_0D0E0F10;
        step();
        checks++;
        if (level_o !== 3'd2) begin
            errors++; $display("FAIL second_push: got lvl %0d want 2", level_o);
        end
        drbg_random_valid_i = 1'b0;
        drbg_done_i = 1'b1;
        step();
        drbg_done_i = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_data_o !== exp_w[i] || out_valid_o !== 1'b1 || level_o !== ((i < 4) ? 3'd2 : 3'd1)) begin
                errors++; $display("FAIL stream_word%0d: got %h lvl %0d want %h lvl %0d", i, out_data_o, level_o, exp_w[i], (i < 4) ? 2 : 1);
            end
            step();
        end
        out_ready_i = 1'b0;
        checks++;
        if (level_o !== 3'd0 || out_valid_o !== 1'b0 || out_data_o !== 32'h0) begin
            errors++; $display("FAIL stream_empty: got lvl %0d vld %b data %h want 0 0 0", level_o, out_valid_o, out_data_o);
        end
    endtask

    task automatic test_backpressure();
        int kind, cyc;
        for (int i = 0; i < 6; i++) begin
            for (int w = 0; w < 4; w++) begin
                cb[i][127 - 32 * w -: 32] = 32'hC000_0000 + 32'(i * 16 + w);
            end
        end
        enable_i = 1'b1;
        wait_cmd(10, kind, cyc);
        checks++;
        if (kind != 3) begin errors++; $display("FAIL bp_gen1: got kind %0d want 3", kind); end
        step();
        answer(cb[0], cb[1]);
        wait_cmd(10, kind, cyc);
        checks++;
        if (kind != 3) begin errors++; $display("FAIL bp_gen2: got kind %0d want 3", kind); end
        step();
        answer(cb[2], cb[3]);
        checks++;
        if (level_o !== 3'd4) begin errors++; $display("FAIL bp_full: got lvl %0d want 4", level_o); end
        wait_cmd(20, kind, cyc);
        checks++;
        if (kind != 0) begin errors++; $display("FAIL bp_no_gen_full: got kind %0d want 0", kind); end
        checks++;
        if (out_data_o !== cb[0][127:96] || out_valid_o !== 1'b1) begin
            errors++; $display("FAIL bp_hold: got %h want %h", out_data_o, cb[0][127:96]);
        end
        out_ready_i = 1'b1;
        repeat (4) step();
        out_ready_i = 1'b0;
        checks++;
        if (level_o !== 3'd3 || out_data_o !== cb[1][127:96]) begin
            errors++; $display("FAIL bp_one_pop: got lvl %0d data %h want 3 %h", level_o, out_data_o, cb[1][127:96]);
        end
        wait_cmd(10, kind, cyc);
        checks++;
        if (kind != 0) begin errors++; $display("FAIL bp_no_gen_3: got kind %0d want 0", kind); end
        out_ready_i = 1'b1;
        repeat (4) step();
        out_ready_i = 1'b0;
        wait_cmd(5, kind, cyc);
        checks++;
        if (kind != 3) begin errors++; $display("FAIL bp_gen3: got kind %0d want 3", kind); end
        step();
        answer(cb[4], cb[5]);
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
        enable_i = 1'b0;
        checks++;
        if (overflow_o !== 1'b0 || level_o !== 3'd4) begin
            errors++; $display("FAIL ovf_pre: got ovf %b lvl %0d want 0 4", overflow_o, level_o);
        end
        drbg_random_valid_i = 1'b1;
        drbg_random_block_i = {4{32'hDEAD_BEEF}};
        step();
        drbg_random_valid_i = 1'b0;
        checks++;
        if (overflow_o !== 1'b1 || level_o !== 3'd4) begin
            errors++; $display("FAIL ovf_flag: got ovf %b lvl %0d want 1 4", overflow_o, level_o);
        end
        out_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = cb[2 + i / 4][127 - 32 * (i % 4) -: 32];
            checks++;
            if (out_data_o !== exp) begin
                errors++; $display("FAIL ovf_drain%0d: got %h want %h", i, out_data_o, exp);
            end
            step();
        end
        out_ready_i = 1'b0;
        checks++;
        if (level_o !== 3'd0) begin errors++; $display("FAIL ovf_empty: got lvl %0d want 0", level_o); end
    endtask

    task automatic test_reseed();
        int kind, cyc, n;
        n = 0;
        kind = 0;
        enable_i = 1'b1;
        out_ready_i = 1'b1;
        for (int k = 0; k < 600; k++) begin
            wait_cmd(40, kind, cyc);
            if (kind != 3) break;
            n++;
            step();
            answer({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        end
        checks++;
        if (n != 506 || kind != 2) begin
            errors++; $display("FAIL reseed_point: got %0d gens then kind %0d want 506 then 2", n, kind);
        end
        step();
        drbg_done_i = 1'b1;
        step();
        drbg_done_i = 1'b0;
        wait_cmd(20, kind, cyc);
        checks++;
        if (kind != 3) begin errors++; $display("FAIL gen_after_reseed: got kind %0d want 3", kind); end
    endtask

    task automatic test_short();
        int kind, cyc;
        checks++;
        if (short_err_o !== 1'b0) begin errors++; $display("FAIL short_pre: got %b want 0", short_err_o); end
        step();
        drbg_done_i = 1'b1;
        step();
        drbg_done_i = 1'b0;
        checks++;
        if (short_err_o !== 1'b1) begin errors++; $display("FAIL short_flag: got %b want 1", short_err_o); end
        wait_cmd(20, kind, cyc);
        checks++;
        if (kind != 2) begin errors++; $display("FAIL short_reseed: got kind %0d want 2", kind); end
        step();
        drbg_done_i = 1'b1;
        step();
        drbg_done_i = 1'b0;
        wait_cmd(20, kind, cyc);
        checks++;
        if (kind != 3) begin errors++; $display("FAIL short_resume: got kind %0d want 3", kind); end
        step();
        enable_i = 1'b0;
        answer(cb[0], cb[1]);
    endtask

    task automatic test_reset_mid();
        int kind, cyc;
        out_ready_i = 1'b1;
        repeat (20) step();
        out_ready_i = 1'b0;
        enable_i = 1'b1;
        wait_cmd(10, kind, cyc);
        checks++;
        if (kind != 3) begin errors++; $display("FAIL mid_gen: got kind %0d want 3", kind); end
        step();
        enable_i = 1'b0;
        drbg_random_valid_i = 1'b1;
        drbg_random_block_i = cb[0];
        step();
        drbg_random_block_i = cb[1];
        step();
        drbg_random_block_i = cb[2];
        step();
        drbg_random_valid_i = 1'b0;
        checks++;
        if (level_o !== 3'd3 || overflow_o !== 1'b1 || short_err_o !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got lvl %0d ovf %b short %b want 3 1 1", level_o, overflow_o, short_err_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (level_o !== 3'd0 || out_valid_o !== 1'b0 || out_data_o !== 32'h0) begin
            errors++; $display("FAIL mid_rst_fifo: got lvl %0d vld %b data %h want 0 0 0", level_o, out_valid_o, out_data_o);
        end
        checks++;
        if ({seeded_o, overflow_o, short_err_o, drbg_instantiate_o, drbg_reseed_o, drbg_generate_o} !== 6'b0) begin
            errors++; $display("FAIL mid_rst_flags: got %b want 000000",
                {seeded_o, overflow_o, short_err_o, drbg_instantiate_o, drbg_reseed_o, drbg_generate_o});
        end
        step();
        rst_n = 1'b1;
        enable_i = 1'b1;
        wait_cmd(5, kind, cyc);
        checks++;
        if (kind != 1 || cyc != 1) begin
            errors++; $display("FAIL mid_restart: got kind %0d at cycle %0d want kind 1 at cycle 1", kind, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_stream();
        test_backpressure();
        test_overflow();
        test_reseed();
        test_short();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/drbg_out_buffer.md
Name: drbg_out_buffer

Overview:
- Downstream consumer and sequencer for the AES-128 CTR_DRBG core.
- After reset it issues instantiate to the DRBG. It then issues fixed-size generate batches whenever the internal block FIFO has room, and schedules reseeds before the DRBG's reseed limit is reached.
- It buffers the 128-bit random blocks and serializes them into OUT_BITS words on a valid/ready stream toward the system consumer.

Parameters:
- DEPTH, 4, FIFO capacity in 128-bit blocks (power of two, >=2)
- BATCH, 2, blocks requested per generate command (1..DEPTH)
- OUT_BITS, 32, output word width (divides 128)
- RESEED_INTERVAL, 510, completed generates allowed between instantiate/reseed events (keeps the DRBG counter below its limit of 511)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable_i  in  1  level; 0 stops new instantiate/generate/reseed commands (in-flight command completes)
- drbg_instantiate_o  out  1  one-cycle command pulse to DRBG
- drbg_reseed_o  out  1  one-cycle command pulse to DRBG
- drbg_generate_o  out  1  one-cycle command pulse to DRBG
- drbg_num_blocks_o  out  16  constant BATCH
- drbg_done_i  in  1  DRBG op-complete pulse
- drbg_random_valid_i  in  1  DRBG block-valid pulse
- drbg_random_block_i  in  128  DRBG random block
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  consumer ready
- out_data_o  out  OUT_BITS  output word
- level_o  out  $clog2(DEPTH)+1  blocks stored, including a partially drained head block
- seeded_o  out  1  high after the first instantiate completes
- overflow_o  out  1  sticky; a block arrived while FIFO full (block dropped)
- short_err_o  out  1  sticky; a generate completed with fewer than BATCH blocks

Behaviour:
- Reset values: all command pulses 0; out_valid_o 0; out_data_o 0; level_o 0; seeded_o 0; overflow_o 0; short_err_o 0; FSM in S_INIT; FIFO empty; gen_count 0.
- Asynchronous reset mid-operation clears everything, including FIFO contents. The next command after reset is instantiate.
- FSM states: S_INIT, S_INIT_WAIT, S_IDLE, S_GEN_WAIT, S_RESEED_WAIT.
- S_INIT:
  - If enable_i, pulse drbg_instantiate_o for 1 cycle and go to S_INIT_WAIT.
- S_INIT_WAIT:
  - On drbg_done_i, set seeded_o, clear gen_count and go to S_IDLE.
- S_IDLE:
  - If enable_i and gen_count == RESEED_INTERVAL, pulse drbg_reseed_o and go to S_RESEED_WAIT.
  - Otherwise, if enable_i and free slots (DEPTH - level_o) >= BATCH, pulse drbg_generate_o, clear rcvd and go to S_GEN_WAIT.
  - Reseed has priority over generate.
- S_GEN_WAIT:
  - Each drbg_random_valid_i pushes drbg_random_block_i into the FIFO and increments rcvd.
  - On drbg_done_i, increment gen_count and go to S_IDLE.
  - If rcvd != BATCH at done, set short_err_o and force gen_count to RESEED_INTERVAL, so the next command is a reseed. A DRBG that rejected the generate therefore gets reseeded.
- S_RESEED_WAIT:
  - On drbg_done_i, clear gen_count and go to S_IDLE.
- Commands are issued only from S_INIT/S_IDLE, at most one per cycle. The next command is no earlier than the cycle after done is sampled.
- Push when full: drop the block, set overflow_o, leave the FIFO unchanged. This cannot happen in correct operation because room is checked at issue time and pops only add room.
- drbg_random_valid_i outside S_GEN_WAIT is still pushed (full rule applies); it does not count toward rcvd.
- Output serialization:
  - The head block is emitted as 128/OUT_BITS words, most significant word first.
  - out_valid_o is high whenever the FIFO is non-empty. out_data_o is the current word of the head block (registered/FIFO-read path, no combinational path from drbg inputs).
  - A word transfers when out_valid_o && out_ready_i; the word index then advances.
  - Transfer of the last word pops the head block and resets the word index to 0.
  - out_data_o must hold stable while out_valid_o && !out_ready_i.
- Push and pop in the same cycle: both occur and level_o is unchanged. A full FIFO that pops its last word while a push arrives accepts the push, so no overflow is flagged.
- Latency: a block pushed into an empty FIFO gives out_valid_o=1 the next cycle.
- Pointers wrap modulo DEPTH. level_o ranges 0..DEPTH.
- enable_i low does not flush the FIFO; output draining continues.

Test Plan:
- Reset then enable_i=1 with a DRBG model:
  - instantiate pulse in cycle 1 after reset release.
  - After done: seeded_o=1, then generate pulse with num_blocks=2.
- DRBG returns blocks 0x00112233_44556677_8899AABB_CCDDEEFF and 0x01..10, with out_ready_i=1:
  - Words come out 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, then the second block MSW first.
  - level_o steps 1, 2, 1, 0 correctly.
- out_ready_i=0 held:
  - FIFO fills to level_o=4 after two generates; no third generate is issued.
  - out_data_o stays stable.
  - Releasing ready for 4 words (one block popped) is not enough room; after 8 words, one new generate is issued.
- Force gen_count to 510 via 510 model generates:
  - Next command is reseed_o, not generate.
  - After done, gen_count=0 and generate resumes.
- DRBG model answers a generate with done only (0 blocks):
  - short_err_o=1 and next command is reseed.
- Inject an unsolicited random_valid while level_o=4:
  - overflow_o=1 and FIFO contents are unchanged.
- Assert rst_n low in S_GEN_WAIT with level_o=3:
  - All outputs return to reset values immediately.
  - Restart begins with instantiate.
